jtag_scan_master: RTL and testbench

//  Bit-banging JTAG host that sits directly upstream of the board TAP: it drives TCK/TMS/TDI into the TAP pins and samples TDO.

---
 rtl/jtag_scan_master.sv | 209 ++++++++++++++++++++
 tb/tb_jtag_scan_master.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_scan_master.sv
// jtag_scan_master
//   Bit-banging JTAG host. Accepts one scan command at a time (TAP reset,
//   IR scan or DR scan of 1..MAX_LEN bits). It walks the TAP from
//   Run-Test/Idle through the scan and back to Run-Test/Idle, and returns
//   the captured TDO bits.
//
//   Each TCK step has a low phase of CLK_DIV clk followed by a high phase of
//   CLK_DIV clk. TMS/TDI change at the start of the low phase. TDO is
//   sampled on the last clk of the high phase.
//
// Parameters
//   MAX_LEN  maximum scan length; width of CMD_DATA / RSP_DATA
//   CLK_DIV  clk cycles per TCK half-period (>= 1)
//
// Ports
//   clk, RESET             system clock, synchronous active-high reset
//   CMD_VALID/CMD_READY    command handshake
//   CMD_TYPE               0 = TAP reset, 1 = IR scan, 2 = DR scan, 3 = error
//   CMD_LEN, CMD_DATA      bit count and TDI bits (LSB shifted first)
//   RSP_VALID/RSP_READY    response handshake; the response is held until consumed
//   RSP_DATA, RSP_ERR      captured TDO (first bit in bit 0) and reject flag
//   BUSY                   high whenever the FSM is not idle
//   TCK, TMS, TDI, TDO     JTAG pins
//   LOOPBACK               only when SCAN_LOOPBACK_EN is defined; when high,
//                          the driven TDI is sampled instead of TDO
//
// Optional feature macro: SCAN_LOOPBACK_EN
module jtag_scan_master #(
    parameter int MAX_LEN = 32,
    parameter int CLK_DIV = 2,
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               RESET,
    input  logic               CMD_VALID,
    output logic               CMD_READY,
    input  logic [1:0]         CMD_TYPE,
    input  logic [LW-1:0]      CMD_LEN,
    input  logic [MAX_LEN-1:0] CMD_DATA,
    output logic               RSP_VALID,
    input  logic               RSP_READY,
    output logic [MAX_LEN-1:0] RSP_DATA,
    output logic               RSP_ERR,
    output logic               BUSY,
    output logic               TCK,
    output logic               TMS,
    output logic               TDI,
    input  logic               TDO
`ifdef SCAN_LOOPBACK_EN
    ,
    input  logic               LOOPBACK
`endif
);

    localparam int PW = $clog2(CLK_DIV + 1);
    localparam int SW = $clog2(MAX_LEN + 7);
    localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_RST, S_SCAN, S_RESP} state_t;

    state_t               state_q, state_n;
    logic                 tck_q, tms_q, tdi_q;
    logic [PW-1:0]        ph_q;
    logic [SW-1:0]        step_q;
    logic [LW-1:0]        bits_q, len_q;
    logic [1:0]           type_q;
    logic [MAX_LEN-1:0]   data_q;
    logic [MAX_LEN-1:0]   rsp_data_q;
    logic                 rsp_valid_q, rsp_err_q;

    logic                 seq, scan, ir, ph_last, high_end, last_step;
    logic                 cur_shift, nxt_tms, nxt_shift, cmd_bad, accept, sample;
    logic [SW-1:0]        len_s, last_idx, step_nx;
    logic [LW-1:0]        idx;
    logic [MAX_LEN-1:0]   data_nx;

    // Number of TCK steps before the first shift: DR 1,0,0 ; IR 1,1,0,0.
    function automatic logic [SW-1:0] pre_len(input logic is_ir);
        return is_ir ? SW'(4) : SW'(3);
    endfunction

    // TMS for step s of the current sequence. Non-scan sequences are the
    // 1,1,1,1,1,0 TAP reset walk.
    function automatic logic tms_at(input logic is_scan, input logic is_ir,
                                    input logic [SW-1:0] s, input logic [SW-1:0] len);
        logic [SW-1:0] pre;
        pre = pre_len(is_ir);
        if (!is_scan)      return (s < SW'(5));
        if (s < pre)       return is_ir ? (s < SW'(2)) : (s == '0);
        if (s < pre + len) return (s == pre + len - SW'(1));
        return (s == pre + len);
    endfunction

    function automatic logic shift_at(input logic is_scan, input logic is_ir,
                                      input logic [SW-1:0] s, input logic [SW-1:0] len);
        logic [SW-1:0] pre;
        pre = pre_len(is_ir);
        return is_scan && (s >= pre) && (s < pre + len);
    endfunction

`ifdef SCAN_LOOPBACK_EN
    assign sample = LOOPBACK ? tdi_q : TDO;
`else
    assign sample = TDO;
`endif

    assign CMD_READY = (state_q == S_IDLE) && !rsp_valid_q;
    assign BUSY      = (state_q != S_IDLE);
    assign RSP_VALID = rsp_valid_q;
    assign RSP_DATA  = rsp_data_q;
    assign RSP_ERR   = rsp_err_q;
    assign TCK       = tck_q;
    assign TMS       = tms_q;
    assign TDI       = tdi_q;

    always_ff @(posedge clk) begin
        if (RESET) state_q <= S_INIT;
        else       state_q <= state_n;
    end

    always_comb begin
        state_n   = state_q;
        seq       = (state_q == S_INIT) || (state_q == S_RST) || (state_q == S_SCAN);
        scan      = (state_q == S_SCAN);
        ir        = (type_q == 2'd1);
        len_s     = SW'(len_q);
        ph_last   = (ph_q == PH_LAST);
        high_end  = seq && tck_q && ph_last;
        last_idx  = scan ? (pre_len(ir) + len_s + SW'(1)) : SW'(5);
        last_step = (step_q == last_idx);
        step_nx   = step_q + SW'(1);
        cur_shift = shift_at(scan, ir, step_q, len_s);
        nxt_tms   = tms_at(scan, ir, step_nx, len_s);
        nxt_shift = shift_at(scan, ir, step_nx, len_s);
        data_nx   = cur_shift ? (data_q >> 1) : data_q;
        idx       = len_q - bits_q;
        cmd_bad   = (CMD_LEN == '0) || (CMD_LEN > LW'(MAX_LEN)) || (CMD_TYPE == 2'd3);
        accept    = (state_q == S_IDLE) && CMD_VALID && !rsp_valid_q;

        case (state_q)
            S_INIT: if (high_end && last_step) state_n = S_IDLE;
            S_IDLE: if (accept) begin
                if (cmd_bad)                state_n = S_RESP;
                else if (CMD_TYPE == 2'd0)  state_n = S_RST;
                else                        state_n = S_SCAN;
            end
            S_RST, S_SCAN: if (high_end && last_step) state_n = S_RESP;
            S_RESP: if (RSP_READY) state_n = S_IDLE;
            default: state_n = S_INIT;
        endcase
    end

    // Sequencer: reset loads step 0 of the TAP reset walk directly, so the
    // first low phase starts in the reset cycle itself.
    always_ff @(posedge clk) begin
        if (RESET) begin
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            ph_q        <= '0;
            step_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else if (accept) begin
            type_q      <= CMD_TYPE;
            len_q       <= CMD_LEN;
            bits_q      <= CMD_LEN;
            data_q      <= CMD_DATA;
            tck_q       <= 1'b0;
            tms_q       <= !cmd_bad;
            tdi_q       <= 1'b0;
            ph_q        <= '0;
            step_q      <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= cmd_bad;
            rsp_valid_q <= cmd_bad;
        end else if (seq) begin
            if (!ph_last) begin
                ph_q <= ph_q + PW'(1);
            end else begin
                ph_q <= '0;
                if (!tck_q) begin
                    tck_q <= 1'b1;
                end else begin
                    // End of the high phase: sample, then fall into the next low phase.
                    tck_q <= 1'b0;
                    if (cur_shift) begin
                        rsp_data_q <= rsp_data_q | ({{(MAX_LEN-1){1'b0}}, sample} << idx);
                        data_q     <= data_nx;
                        bits_q     <= bits_q - LW'(1);
                    end
                    if (last_step) begin
                        tms_q       <= 1'b0;
                        tdi_q       <= 1'b0;
                        rsp_valid_q <= (state_q != S_INIT);
                    end else begin
                        step_q <= step_nx;
                        tms_q  <= nxt_tms;
                        tdi_q  <= nxt_shift & data_nx[0];
                    end
                end
            end
        end else if ((state_q == S_RESP) && RSP_READY) begin
            rsp_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jtag_scan_master.sv
module tb_jtag_scan_master;
    localparam int MAX_LEN = 32;
    localparam int CLK_DIV = 2;
    localparam int LW      = $clog2(MAX_LEN + 1);
    localparam int LIMIT   = 2000;

    // TAP states
    localparam int TLR = 0, RTI = 1, SDS = 2, CDR = 3, SDR = 4, E1D = 5, PDR = 6, E2D = 7;
    localparam int UDR = 8, SIS = 9, CIR = 10, SIR = 11, E1I = 12, PIR = 13, E2I = 14, UIR = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               RESET, CMD_VALID, CMD_READY, RSP_VALID, RSP_READY, RSP_ERR, BUSY;
    logic [1:0]         CMD_TYPE;
    logic [LW-1:0]      CMD_LEN;
    logic [31:0]        CMD_DATA, RSP_DATA;
    logic               TCK, TMS, TDI;
    logic               tdo_m = 1'b0;
    logic               lb = 1'b0;

    jtag_scan_master #(.MAX_LEN(MAX_LEN), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .RESET(RESET),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_TYPE(CMD_TYPE),
        .CMD_LEN(CMD_LEN), .CMD_DATA(CMD_DATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
        .RSP_ERR(RSP_ERR), .BUSY(BUSY),
        .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(tdo_m)
`ifdef SCAN_LOOPBACK_EN
        , .LOOPBACK(lb)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- TAP model (TDO updates on rising TCK) ----------------
    int          tap_st = SDR;
    int          tck_total = 0;
    int          shift_total = 0;
    logic        tms_hist [0:4095];
    logic        tdi_hist [0:4095];
    logic [31:0] sr = '0;
    logic [31:0] dr_cap = '0;
    logic [31:0] ir_cap = 32'h1;

    function automatic int tap_next(input int s, input logic m);
        case (s)
            TLR: return m ? TLR : RTI;
            RTI: return m ? SDS : RTI;
            SDS: return m ? SIS : CDR;
            CDR: return m ? E1D : SDR;
            SDR: return m ? E1D : SDR;
            E1D: return m ? UDR : PDR;
            PDR: return m ? E2D : PDR;
            E2D: return m ? UDR : SDR;
            UDR: return m ? SDS : RTI;
            SIS: return m ? TLR : CIR;
            CIR: return m ? E1I : SIR;
            SIR: return m ? E1I : SIR;
            E1I: return m ? UIR : PIR;
            PIR: return m ? E2I : PIR;
            E2I: return m ? UIR : SIR;
            default: return m ? SDS : RTI;
        endcase
    endfunction

    always @(posedge TCK) begin
        tms_hist[tck_total & 4095] <= TMS;
        tck_total <= tck_total + 1;
        if (tap_st == CDR) sr <= dr_cap;
        if (tap_st == CIR) sr <= ir_cap;
        if (tap_st == SDR || tap_st == SIR) begin
            tdo_m <= sr[0];
            sr    <= {TDI, sr[31:1]};
            tdi_hist[shift_total & 4095] <= TDI;
            shift_total <= shift_total + 1;
        end
        tap_st <= tap_next(tap_st, TMS);
    end

    function automatic logic [31:0] tms_bits(input int base, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = tms_hist[(base + i) & 4095];
        return r;
    endfunction

    function automatic logic [31:0] tdi_bits(input int base, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = tdi_hist[(base + i) & 4095];
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] data;
        logic        err;
        int          tcks;
        int          shifts;
        logic [31:0] tdi;
    } exp_t;
    exp_t sb[$];
    int   last_tb0;

    task automatic send(input logic [1:0] t, input logic [LW-1:0] l, input logic [31:0] d);
        int n;
        CMD_TYPE = t; CMD_LEN = l; CMD_DATA = d; CMD_VALID = 1'b1;
        n = 0;
        while (!CMD_READY && n < LIMIT) begin @(negedge clk); n++; end
        if (n >= LIMIT) check("accept_timeout", 64'(0), 64'(1));
        @(negedge clk);
        CMD_VALID = 1'b0;
    endtask

    task automatic run_cmd(input logic [1:0] t, input logic [LW-1:0] l, input logic [31:0] d,
                           input bit hold);
        exp_t        e, g;
        logic [31:0] mask;
        bit          bad;
        int          tb0, sb0, n, nbad;
        bad  = (l == 0) || (int'(l) > MAX_LEN) || (t == 2'd3);
        mask = (int'(l) >= 32) ? 32'hFFFF_FFFF : ((32'h1 << l) - 32'h1);
        e.err    = bad;
        e.tcks   = bad ? 0 : (t == 2'd0) ? 6 : (t == 2'd1) ? int'(l) + 6 : int'(l) + 5;
        e.shifts = (bad || t == 2'd0) ? 0 : int'(l);
        e.data   = (bad || t == 2'd0) ? 32'h0 :
                   lb ? (d & mask) : (((t == 2'd1) ? ir_cap : dr_cap) & mask);
        e.tdi    = (e.shifts != 0) ? (d & mask) : 32'h0;
        sb.push_back(e);
        tb0 = tck_total; sb0 = shift_total; last_tb0 = tb0;
        send(t, l, d);
        if (bad) check("err_next_clk", 64'(RSP_VALID), 64'(1));
        n = 0;
        while (!RSP_VALID && n < LIMIT) begin @(negedge clk); n++; end
        if (n >= LIMIT) check("rsp_timeout", 64'(0), 64'(1));
        g = sb.pop_front();
        check("rsp_data",  64'(RSP_DATA), 64'(g.data));
        check("rsp_err",   64'(RSP_ERR), 64'(g.err));
        check("tck_count", 64'(tck_total - tb0), 64'(g.tcks));
        check("shifts",    64'(shift_total - sb0), 64'(g.shifts));
        check("tdi_bits",  64'(tdi_bits(sb0, g.shifts)), 64'(g.tdi));
        check("tap_rti",   64'(tap_st), 64'(RTI));
        check("idle_pins", 64'({TCK, TMS, TDI}), 64'(0));
        if (hold) begin
            CMD_TYPE = 2'd2; CMD_LEN = LW'(8); CMD_DATA = 32'h0; CMD_VALID = 1'b1;
            nbad = 0;
            repeat (20) begin
                @(negedge clk);
                if (CMD_READY !== 1'b0 || RSP_VALID !== 1'b1 || RSP_DATA !== g.data ||
                    RSP_ERR !== g.err || TCK !== 1'b0) nbad++;
            end
            check("hold_stable", 64'(nbad), 64'(0));
        end
        @(negedge clk); RSP_READY = 1'b1;
        @(negedge clk); RSP_READY = 1'b0;
        check("rsp_consumed", 64'(RSP_VALID), 64'(0));
        check("ready_again",  64'(CMD_READY), 64'(1));
        CMD_VALID = 1'b0;
    endtask

    initial begin
        int          n, tb0, sb0;
        bit          saw;
        logic [31:0] rd;
        logic [LW-1:0] rl;
        RESET = 1'b1; CMD_VALID = 1'b0; CMD_TYPE = 2'd0; CMD_LEN = '0; CMD_DATA = '0;
        RSP_READY = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pins",  64'({TCK, TMS, TDI}), 64'(3'b010));
        check("rst_ready", 64'(CMD_READY), 64'(0));
        check("rst_rsp",   64'({RSP_VALID, RSP_ERR, RSP_DATA}), 64'(0));
        check("rst_busy",  64'(BUSY), 64'(1));

        // INIT walk after release
        tb0 = tck_total;
        RESET = 1'b0;
        n = 0;
        while (!CMD_READY && n < LIMIT) begin @(negedge clk); n++; end
        check("init_latency", 64'(n >= 24 && n <= 25), 64'(1));
        check("init_tcks",    64'(tck_total - tb0), 64'(6));
        check("init_tms",     64'(tms_bits(tb0, 6)), 64'(6'h1F));
        check("init_tap",     64'(tap_st), 64'(RTI));
        check("init_busy",    64'(BUSY), 64'(0));

        dr_cap = 32'h0000_00A5;
        run_cmd(2'd2, LW'(8), 32'h3C, 1'b0);
        run_cmd(2'd1, LW'(4), 32'h7, 1'b0);
        check("ir_tms", 64'(tms_bits(last_tb0, 10)), 64'(10'h183));
        run_cmd(2'd0, LW'(1), 32'h0, 1'b0);
        run_cmd(2'd2, LW'(0), 32'hFF, 1'b0);
        run_cmd(2'd2, LW'(33), 32'hFF, 1'b0);
        run_cmd(2'd3, LW'(8), 32'hFF, 1'b0);

        dr_cap = $urandom;
        run_cmd(2'd2, LW'(32), $urandom, 1'b1);
        run_cmd(2'd2, LW'(1), 32'h1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            dr_cap = $urandom;
            rd = $urandom;
            rl = LW'($urandom_range(1, MAX_LEN));
            run_cmd((k % 2 == 0) ? 2'd2 : 2'd1, rl, rd, 1'b0);
        end

        // RESET in the middle of a DR shift
        dr_cap = 32'h1234;
        sb0 = shift_total;
        send(2'd2, LW'(16), 32'hFFFF);
        n = 0;
        while ((shift_total - sb0) < 3 && n < LIMIT) begin @(negedge clk); n++; end
        if (n >= LIMIT) check("midscan_timeout", 64'(0), 64'(1));
        RESET = 1'b1;
        @(negedge clk);
        RESET = 1'b0;
        check("midrst_pins", 64'({TCK, TMS}), 64'(2'b01));
        check("midrst_rsp",  64'(RSP_VALID), 64'(0));
        tb0 = tck_total; saw = 1'b0; n = 0;
        while (!CMD_READY && n < LIMIT) begin
            @(negedge clk); n++;
            if (RSP_VALID) saw = 1'b1;
        end
        check("midrst_no_rsp", 64'(saw), 64'(0));
        check("midrst_tcks",   64'(tck_total - tb0), 64'(6));
        check("midrst_tms",    64'(tms_bits(tb0, 6)), 64'(6'h1F));
        check("midrst_tap",    64'(tap_st), 64'(RTI));

`ifdef SCAN_LOOPBACK_EN
        lb = 1'b1;
        dr_cap = 32'h0;
        run_cmd(2'd2, LW'(16), 32'h0000_BEEF, 1'b0);
        check("loopback", 64'(RSP_DATA), 64'(32'h0000_BEEF));
        lb = 1'b0;
`endif

        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
